mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: READ_LATENCY, default 1, RAM clock edges from address to valid ram_rd; legal range 1..4.
REQ-002 Parameter: ADDR_WIDTH, default 32, address width of both ports and the RAM.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 p0_req, p0_we  input  1 each  port 0 (instruction fetch): access request, write enable.
REQ-006 p0_addr  input  ADDR_WIDTH  port 0 byte address; p0_wdata  input  32; p0_be  input  4.
REQ-007 p0_gnt  output  1  port 0 access accepted this cycle.
REQ-008 p0_rvalid  output  1  port 0 read data valid; p0_rdata  output  32.
REQ-009 p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_gnt, p1_rvalid, p1_rdata: same widths and meanings for port 1 (CPU data).
REQ-010 ram_a  output  ADDR_WIDTH  RAM address; ram_wd  output  32; ram_be  output  4; ram_we  output  1.
REQ-011 ram_rd  input  32  RAM read data, valid READ_LATENCY edges after ram_a is presented.

Function
REQ-012 States: IDLE, WAIT; the arbiter SHALL allow at most one outstanding read.
REQ-013 IDLE, no request: ram_we=0; ram_a, ram_wd and ram_be hold their last values; no gnt.
REQ-014 IDLE, one port requesting: that port SHALL be granted combinationally in the same cycle (gnt=1); its addr/we/wdata/be SHALL be driven to the RAM in that cycle.
REQ-015 IDLE, both ports requesting: round-robin; grant the port not granted most recently; after reset, port 1 wins the first tie.
REQ-016 Granted write: ram_we=1 for exactly that cycle; state stays IDLE; no rvalid; back-to-back writes SHALL complete at one per cycle.
REQ-017 Granted read: ram_we=0; the state SHALL go to WAIT; a latency counter loads READ_LATENCY-1; the owner port is recorded.
REQ-018 WAIT: counter decrements each cycle. When the counter is 0, assert the owner's rvalid for exactly one cycle with rdata=ram_rd, then return to IDLE on the next edge.
REQ-019 WAIT: no gnt to either port; ram_a SHALL be held at the read address; ram_we=0.
REQ-020 READ_LATENCY=1: the read is granted in cycle N; rvalid SHALL be asserted in cycle N+1; the next grant SHALL come no earlier than cycle N+2.
REQ-021 pX_rdata SHALL be registered and hold its last valid value when rvalid=0. Only the owner port's rdata updates.
REQ-022 Requesters hold req and payload stable until gnt; the arbiter SHALL NOT latch a request that drops before grant.
REQ-023 The round-robin pointer SHALL update only on a grant, including an uncontested grant.
REQ-024 A port that is not granted SHALL see gnt=0; a port requesting continuously against an alternating competitor SHALL be granted within 2 grants (no starvation).
REQ-025 p0_gnt and p1_gnt SHALL never both be 1; p0_rvalid and p1_rvalid SHALL never both be 1.

Reset
REQ-026 While rst=1 at a rising edge: state SHALL be IDLE; counter=0; the round-robin pointer SHALL select port 1 for the first tie; p0_rdata and p1_rdata SHALL be 0.
REQ-027 Outputs during and after reset until the first request: all gnt=0, rvalid=0, ram_we=0, ram_a=0, ram_wd=0, ram_be=0.
REQ-028 Reset asserted in WAIT: the pending read SHALL be abandoned with no rvalid after reset; RAM data returning later SHALL be ignored.

Verification
REQ-029 p1 write addr 0x10, wdata 0xDEADBEEF, be 0xF -> same cycle p1_gnt=1, ram_we=1, ram_a=0x10; next cycle a p1 read of 0x10 is granted, and p1_rvalid=1 with p1_rdata=0xDEADBEEF one cycle later.
REQ-030 After reset, p0 and p1 read simultaneously (LAT=1) -> p1 granted in cycle 0, p1_rvalid in cycle 1; p0 granted in cycle 2, p0_rvalid in cycle 3.
REQ-031 Both ports hold req for 8 cycles of writes -> grants alternate p1,p0,p1,p0...; no cycle has both gnt=1.
REQ-032 READ_LATENCY=3, p0 read addr 0x4 -> p0_rvalid exactly 3 cycles after grant; no gnt in between despite p1_req=1.
REQ-033 rst pulsed one cycle after a read grant -> no rvalid afterwards; all outputs reset values; the next tie is granted to p1.
REQ-034 Byte write be=0b0100 with wdata 0x00AB0000 to a RAM word holding 0x11223344, then a read -> rdata=0x11AB3344.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter onto a single-port RAM.
// Grants are combinational in IDLE; reads block both ports until the data returns.
module mem_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [31:0]           p0_wdata,
    input  logic [3:0]            p0_be,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [31:0]           p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wdata,
    input  logic [3:0]            p1_be,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [31:0]           p1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [31:0]           ram_wd,
    output logic [3:0]            ram_be,
    output logic                  ram_we,
    input  logic [31:0]           ram_rd
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);
    state_t                state;
    logic [1:0]            cnt;
    logic                  last, owner, sel1, gnt, done;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [31:0]           wd_q, rd0_q, rd1_q;
    logic [3:0]            be_q;
    // last holds the most recently granted port; a tie goes to the other one
    always_comb begin
        sel1      = p1_req && (!p0_req || !last);
        gnt       = !rst && state == IDLE && (p0_req || p1_req);
        p1_gnt    = gnt && sel1;
        p0_gnt    = gnt && !sel1;
        ram_a     = gnt ? (sel1 ? p1_addr : p0_addr) : a_q;
        ram_wd    = gnt ? (sel1 ? p1_wdata : p0_wdata) : wd_q;
        ram_be    = gnt ? (sel1 ? p1_be : p0_be) : be_q;
        ram_we    = gnt && (sel1 ? p1_we : p0_we);
        done      = !rst && state == WAIT && cnt == 2'd0;
        p0_rvalid = done && !owner;
        p1_rvalid = done && owner;
        p0_rdata  = p0_rvalid ? ram_rd : rd0_q;
        p1_rdata  = p1_rvalid ? ram_rd : rd1_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            last  <= 1'b0;
            owner <= 1'b0;
            a_q   <= '0;
            wd_q  <= 32'd0;
            be_q  <= 4'd0;
            rd0_q <= 32'd0;
            rd1_q <= 32'd0;
        end else begin
            if (gnt) begin
                a_q  <= ram_a;
                wd_q <= ram_wd;
                be_q <= ram_be;
                last <= sel1;
                if (!ram_we) begin
                    state <= WAIT;
                    cnt   <= LAT_M1;
                    owner <= sel1;
                end
            end
            if (state == WAIT) begin
                if (cnt == 2'd0) begin
                    state <= IDLE;
                    if (owner) rd1_q <= ram_rd;
                    else rd0_q <= ram_rd;
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus corner sequences; read data checked through a scoreboard.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, q0_req = 0, q1_req = 0;
    logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
    logic [3:0]  p0_be = 0, p1_be = 0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we;
    logic [31:0] p0_rdata, p1_rdata, ram_a, ram_wd, ram_rd;
    logic [3:0]  ram_be;
    logic        p0_gnt_3, p1_gnt_3, p0_rvalid_3, p1_rvalid_3, ram_we_3;
    logic [31:0] p0_rdata_3, p1_rdata_3, ram_a_3, ram_wd_3, ram_rd_3;
    logic [3:0]  ram_be_3;

    mem_arbiter #(.READ_LATENCY(1), .ADDR_WIDTH(32)) u1 (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_a(ram_a), .ram_wd(ram_wd), .ram_be(ram_be), .ram_we(ram_we), .ram_rd(ram_rd));

    mem_arbiter #(.READ_LATENCY(3), .ADDR_WIDTH(32)) u3 (
        .clk(clk), .rst(rst),
        .p0_req(q0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_gnt(p0_gnt_3), .p0_rvalid(p0_rvalid_3), .p0_rdata(p0_rdata_3),
        .p1_req(q1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_gnt(p1_gnt_3), .p1_rvalid(p1_rvalid_3), .p1_rdata(p1_rdata_3),
        .ram_a(ram_a_3), .ram_wd(ram_wd_3), .ram_be(ram_be_3), .ram_we(ram_we_3), .ram_rd(ram_rd_3));

    // RAM behind u1: one-edge read latency, byte-enabled writes
    logic [31:0] mem [16] = '{default: 32'h11223344};
    logic [31:0] ref_mem [16] = '{default: 32'h11223344};
    always @(posedge clk) begin
        ram_rd <= mem[ram_a[5:2]];
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_a[5:2]][8*b +: 8] <= ram_wd[8*b +: 8];
    end

    // RAM behind u3: three-edge pipeline returning the inverted address
    logic [31:0] s3 [3];
    always @(posedge clk) begin
        s3[0] <= ~ram_a_3;
        s3[1] <= s3[0];
        s3[2] <= s3[1];
    end
    assign ram_rd_3 = s3[2];

    int checks = 0;
    int errors = 0;
    logic [32:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        p0_req = 0; p1_req = 0; q0_req = 0; q1_req = 0; p0_we = 0; p1_we = 0;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] wd0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] wd1,
                         input logic [3:0] be);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = wd0; p0_be = be;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = wd1; p1_be = be;
    endtask

    // expected effect of a grant: update the reference RAM or queue the read result
    task automatic ref_apply(input logic port, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
            sb.push_back({port, ref_mem[a[5:2]]});
        end
    endtask

    task automatic do_reset;
        rst = 1;
        idle_in;
        cyc;
        cyc;
        rst = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_excl", {31'd0, p0_gnt & p1_gnt}, 32'd0);
            chk("rvalid_excl", {31'd0, p0_rvalid & p1_rvalid}, 32'd0);
            chk("gnt_excl_3", {31'd0, p0_gnt_3 & p1_gnt_3}, 32'd0);
            if (p0_rvalid || p1_rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    chk("rvalid_port", {31'd0, p1_rvalid}, {31'd0, e[32]});
                    chk("rdata", p1_rvalid ? p1_rdata : p0_rdata, e[31:0]);
                end
            end
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0;
        logic        r1, w1;
        logic [31:0] a1;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        g0, g1, we;
        logic [31:0] ea;
    } vec_t;
    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b1, 32'h10};
        vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h10};
        vecs[3]  = '{1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b1, 32'h20};
        vecs[4]  = '{1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b1, 32'h24};
        vecs[5]  = '{1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 32'h00, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'h20};
        vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h24, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h24};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 32'h24};
        vecs[8]  = '{1'b1, 1'b1, 32'h04, 1'b0, 1'b0, 32'h00, 32'h00AB0000, 4'h4, 1'b1, 1'b0, 1'b1, 32'h04};
        vecs[9]  = '{1'b1, 1'b0, 32'h04, 1'b0, 1'b0, 32'h00, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'h04};
        vecs[10] = '{1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h10};

        // reset state, during and after reset
        idle_in;
        cyc;
        @(negedge clk);
        chk("rst_ctl", {26'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we, 1'b0}, 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        cyc;
        rst = 0;
        @(negedge clk);
        chk("post_rst_ctl", {23'd0, ram_be, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we}, 32'd0);
        chk("post_rst_ram_a", ram_a, 32'd0);
        chk("post_rst_ram_wd", ram_wd, 32'd0);
        chk("post_rst_rdata", p0_rdata | p1_rdata, 32'd0);
        cyc;

        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].wd,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].wd, vecs[i].be);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), {30'd0, p0_gnt, p1_gnt}, {30'd0, vecs[i].g0, vecs[i].g1});
            chk($sformatf("v%0d_we", i), {31'd0, ram_we}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_ram_a", i), ram_a, vecs[i].ea);
            if (vecs[i].g1) ref_apply(1'b1, vecs[i].w1, vecs[i].a1, vecs[i].wd, vecs[i].be);
            else if (vecs[i].g0) ref_apply(1'b0, vecs[i].w0, vecs[i].a0, vecs[i].wd, vecs[i].be);
            cyc;
            if ((vecs[i].g0 || vecs[i].g1) && !vecs[i].we) begin
                idle_in;
                cyc;
            end
        end
        idle_in;
        cyc;

        // simultaneous reads after reset: p1 first, p0 two cycles later
        do_reset;
        drive(1, 0, 32'h20, 0, 1, 0, 32'h04, 0, 4'hF);
        @(negedge clk);
        chk("tie_c0_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
        ref_apply(1'b1, 1'b0, 32'h04, 0, 4'hF);
        cyc;
        p1_req = 0;
        @(negedge clk);
        chk("tie_c1_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
        chk("tie_c1_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd1);
        cyc;
        @(negedge clk);
        chk("tie_c2_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd2);
        ref_apply(1'b0, 1'b0, 32'h20, 0, 4'hF);
        cyc;
        p0_req = 0;
        @(negedge clk);
        chk("tie_c3_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd2);
        cyc;

        // both ports streaming writes alternate p1, p0, ...
        do_reset;
        drive(1, 1, 32'h30, 32'h0A0A0A0A, 1, 1, 32'h34, 32'h0B0B0B0B, 4'hF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_gnt", k), {30'd0, p0_gnt, p1_gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_ram_a", k), ram_a, (k % 2 == 0) ? 32'h34 : 32'h30);
            chk($sformatf("rr%0d_ram_wd", k), ram_wd, (k % 2 == 0) ? 32'h0B0B0B0B : 32'h0A0A0A0A);
            chk($sformatf("rr%0d_we", k), {31'd0, ram_we}, 32'd1);
            if (k % 2 == 0) ref_apply(1'b1, 1'b1, 32'h34, 32'h0B0B0B0B, 4'hF);
            else ref_apply(1'b0, 1'b1, 32'h30, 32'h0A0A0A0A, 4'hF);
            cyc;
        end
        drive(0, 0, 32'h0, 0, 1, 0, 32'h30, 0, 4'hF);
        @(negedge clk);
        chk("rr_readback_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
        ref_apply(1'b1, 1'b0, 32'h30, 0, 4'hF);
        cyc;
        idle_in;
        cyc;

        // latency 3: p0 read, p1 kept waiting until the data returns
        do_reset;
        p0_we = 0; p0_addr = 32'h04; q0_req = 1;
        @(negedge clk);
        chk("l3_c0_gnt", {30'd0, p0_gnt_3, p1_gnt_3}, 32'd2);
        cyc;
        q0_req = 0; p1_we = 0; p1_addr = 32'h08; q1_req = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("l3_c%0d_gnt", k), {30'd0, p0_gnt_3, p1_gnt_3}, 32'd0);
            chk($sformatf("l3_c%0d_rvalid", k), {30'd0, p0_rvalid_3, p1_rvalid_3}, (k == 3) ? 32'd2 : 32'd0);
            if (k == 3) chk("l3_rdata", p0_rdata_3, 32'hFFFFFFFB);
            cyc;
        end
        @(negedge clk);
        chk("l3_c4_gnt", {30'd0, p0_gnt_3, p1_gnt_3}, 32'd1);
        cyc;
        q1_req = 0;
        cyc;

        // reset one cycle after a read grant abandons the read
        do_reset;
        drive(1, 0, 32'h20, 0, 0, 0, 32'h0, 0, 4'hF);
        @(negedge clk);
        chk("abort_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd2);
        cyc;
        idle_in;
        rst = 1;
        @(negedge clk);
        chk("abort_rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        cyc;
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort%0d_ctl", k), {27'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_we}, 32'd0);
            chk($sformatf("abort%0d_ram_a", k), ram_a, 32'd0);
            chk($sformatf("abort%0d_rdata", k), p0_rdata, 32'd0);
            cyc;
        end
        drive(1, 1, 32'h38, 32'h12345678, 1, 1, 32'h3C, 32'h9ABCDEF0, 4'hF);
        @(negedge clk);
        chk("abort_tie_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
        ref_apply(1'b1, 1'b1, 32'h3C, 32'h9ABCDEF0, 4'hF);
        cyc;
        idle_in;
        cyc;
        cyc;

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
